i2c_txn_sched: RTL and testbench

Host-side transaction scheduler sitting directly upstream of the I2C master byte interface. It buffers host commands (address, direction, length) and write bytes, then replays each command to the master as one contiguous pushin burst. It collects read bytes returned on the master's pushout/data_out into a read FIFO drained by the host. Read space is reserved before dispatch, so returned bytes are never dropped in normal operation.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/i2c_txn_sched.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_txn_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction scheduler.
//   i2c_cmd_t     : one queued host command {addr, write, len}
//   sched_state_e : dispatch FSM states
//   I2C_READ_FILL : filler byte sent in the data slots of a read burst, used only as a length count
package i2c_pkg;

  typedef struct packed {
    logic [6:0] addr;
    logic       write;
    logic [3:0] len;
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ADDR,
    DATA
  } sched_state_e;

  localparam logic [7:0] I2C_READ_FILL = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
//   CLK, RST               : clock, synchronous active-high reset
//   push_valid/push_ready  : write handshake, push_data is stored on valid&ready
//   pop_valid/pop_ready    : read handshake, pop_data is the current head
//   count                  : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal means empty, equal index with
  // differing wrap bit means full.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_valid  = (wr_ptr != rd_ptr);
  assign pop_data   = mem[rd_ptr[AW-1:0]];
  assign do_pop     = pop_valid && pop_ready;
  // A full FIFO still accepts a push in a cycle where the head is popped.
  assign push_ready = !full || do_pop;
  assign do_push    = push_valid && push_ready;
  assign count      = wr_ptr - rd_ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2c_txn_sched.sv
// Host-side transaction scheduler in front of an I2C master byte interface.
// Buffers commands and write bytes, replays each command as one contiguous
// m_pushin burst (address byte then len data slots), and collects returned
// read bytes into a read FIFO. Read space is reserved before a read is
// dispatched so returned bytes are not lost.
//   CLK, RST                      : clock, synchronous active-high reset
//   cmd_valid/ready/addr/write/len: host command input
//   wr_valid/ready/data           : host write-byte input
//   rd_valid/ready/data           : host read-byte output
//   m_canin, m_pushin, m_data_in  : burst toward the master
//   m_pushout, m_data_out         : read bytes returned by the master
//   busy                          : FSM active or read bytes still expected
//   rd_overflow                   : sticky, a returned byte hit a full read FIFO
module i2c_txn_sched
  import i2c_pkg::*;
#(
  parameter int CDEPTH = 4,
  parameter int WDEPTH = 16,
  parameter int RDEPTH = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_write,
  input  logic [3:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  input  logic       m_canin,
  output logic       m_pushin,
  output logic [7:0] m_data_in,
  input  logic       m_pushout,
  input  logic [7:0] m_data_out,
  output logic       busy,
  output logic       rd_overflow
);

  localparam int CCW = $clog2(CDEPTH) + 1;
  localparam int WCW = $clog2(WDEPTH) + 1;
  localparam int RCW = $clog2(RDEPTH) + 1;
  localparam logic [RCW+1:0] RD_CAP = (RCW+2)'(RDEPTH);

  sched_state_e   state;
  logic [3:0]     remaining;
  logic           cur_write;
  logic [RCW-1:0] outstanding;
  logic [RCW-1:0] out_sum;
  logic [RCW-1:0] out_next;

  i2c_cmd_t       cmd_in;
  i2c_cmd_t       cmd_head;
  logic           cmd_pop_valid;
  logic           cmd_pop;
  logic [CCW-1:0] cmd_count;

  logic           wr_pop_valid;
  logic           wr_pop;
  logic [7:0]     wr_head;
  logic [WCW-1:0] wr_count;

  logic           rd_push_ready;
  logic [RCW-1:0] rd_count;

  logic           write_ok;
  logic           read_ok;
  logic           launch_ok;
  logic           dispatch_read;

  assign cmd_in = {cmd_addr, cmd_write, cmd_len};

  sync_fifo #(.WIDTH($bits(i2c_cmd_t)), .DEPTH(CDEPTH)) u_cmd_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  (cmd_in),
    .pop_valid  (cmd_pop_valid),
    .pop_ready  (cmd_pop),
    .pop_data   (cmd_head),
    .count      (cmd_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(WDEPTH)) u_wr_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push_valid (wr_valid),
    .push_ready (wr_ready),
    .push_data  (wr_data),
    .pop_valid  (wr_pop_valid),
    .pop_ready  (wr_pop),
    .pop_data   (wr_head),
    .count      (wr_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RDEPTH)) u_rd_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push_valid (m_pushout),
    .push_ready (rd_push_ready),
    .push_data  (m_data_out),
    .pop_valid  (rd_valid),
    .pop_ready  (rd_ready),
    .pop_data   (rd_data),
    .count      (rd_count)
  );

  // A write may only start once every byte of its burst is buffered; a read
  // may only start once the read FIFO can hold everything already promised
  // plus this command's bytes.
  assign write_ok  = wr_count >= {{(WCW-4){1'b0}}, cmd_head.len};
  assign read_ok   = ({2'b00, rd_count} + {2'b00, outstanding}
                      + {{(RCW-2){1'b0}}, cmd_head.len}) <= RD_CAP;
  assign launch_ok = cmd_head.write ? write_ok : read_ok;

  assign cmd_pop = (state == ADDR) && m_canin && cmd_pop_valid;

  // The first write byte is popped on the edge the address is accepted, the
  // rest on each DATA edge that still has another byte to present.
  assign wr_pop = wr_pop_valid &&
                  (((state == ADDR) && m_canin && cmd_head.write && (cmd_head.len != 4'd0)) ||
                   ((state == DATA) && cur_write && (remaining != 4'd1)));

  assign dispatch_read = (state == ADDR) && m_canin && !cmd_head.write;

  // Reservation on dispatch and release on return combine in one update; a
  // return with nothing outstanding leaves the counter at zero.
  always_comb begin
    out_sum  = outstanding + (dispatch_read ? {{(RCW-4){1'b0}}, cmd_head.len} : '0);
    out_next = out_sum;
    if (m_pushout && (out_sum != '0)) out_next = out_sum - RCW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      outstanding <= '0;
      rd_overflow <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (m_pushout && !rd_push_ready) rd_overflow <= 1'b1;
    end
  end

  // Dispatch FSM. m_pushin/m_data_in are registered here so the master sees
  // a glitch-free burst: address in ADDR (held until m_canin), then exactly
  // len data slots in DATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      m_pushin  <= 1'b0;
      m_data_in <= 8'h00;
      remaining <= 4'd0;
      cur_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_count != '0) state <= CHECK;
        end
        CHECK: begin
          if (launch_ok) begin
            m_pushin  <= 1'b1;
            m_data_in <= {cmd_head.addr, cmd_head.write};
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_canin) begin
            if (cmd_head.len == 4'd0) begin
              m_pushin  <= 1'b0;
              m_data_in <= 8'h00;
              state     <= IDLE;
            end else begin
              remaining <= cmd_head.len;
              cur_write <= cmd_head.write;
              m_data_in <= cmd_head.write ? wr_head : I2C_READ_FILL;
              state     <= DATA;
            end
          end
        end
        DATA: begin
          if (remaining == 4'd1) begin
            m_pushin  <= 1'b0;
            m_data_in <= 8'h00;
            state     <= IDLE;
          end else begin
            remaining <= remaining - 4'd1;
            m_data_in <= cur_write ? wr_head : I2C_READ_FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Scoreboard bench for i2c_txn_sched. Stimulus tasks push expected commands,
// write bytes and read returns into queues; a negedge monitor checks every
// burst beat and every host read pop against those queues.
module tb_i2c_txn_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_write = 1'b0;
  logic [3:0] cmd_len = 4'h0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       m_canin = 1'b0;
  logic       m_pushin;
  logic [7:0] m_data_in;
  logic       m_pushout = 1'b0;
  logic [7:0] m_data_out = 8'h00;
  logic       busy;
  logic       rd_overflow;

  i2c_txn_sched #(.CDEPTH(4), .WDEPTH(16), .RDEPTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .m_canin    (m_canin),
    .m_pushin   (m_pushin),
    .m_data_in  (m_data_in),
    .m_pushout  (m_pushout),
    .m_data_out (m_data_out),
    .busy       (busy),
    .rd_overflow(rd_overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] addr;
    bit         write;
    int         len;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] pend[$];

  int n_checks = 0;
  int n_pass   = 0;

  bit         canin_rand = 0;
  bit         canin_dir  = 1;
  bit         host_rand  = 0;
  bit         host_dir   = 0;
  bit         slave_rand = 0;
  bit         ret_seq    = 0;
  logic [7:0] ret_base   = 8'h00;
  int         pop_req = 0, pop_done = 0;
  int         drop_req = 0, drop_done = 0;
  int         keep_req = 0, keep_done = 0;

  int         mon_rem = 0;
  bit         mon_write = 0;
  bit         mon_low = 0;
  cmd_t       mon_c;
  logic [7:0] mon_exp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // Master-side handshake model: m_canin either fixed or randomly throttled.
  always @(posedge CLK) begin
    #1;
    if (canin_rand) m_canin = ($urandom_range(0, 3) != 0);
    else            m_canin = canin_dir;
  end

  // Host read side: random, fixed level, or an exact number of single pops.
  always @(posedge CLK) begin
    #1;
    if (host_rand) rd_ready = ($urandom_range(0, 1) == 1);
    else if (pop_req != pop_done) begin
      rd_ready = 1'b1;
      pop_done++;
    end else rd_ready = host_dir;
  end

  // Slave model returning read bytes requested by observed read bursts, plus
  // unsolicited bytes on demand (one that must be dropped, one that must be kept).
  always @(posedge CLK) begin
    #1;
    m_pushout = 1'b0;
    if (drop_req != drop_done) begin
      m_pushout  = 1'b1;
      m_data_out = 8'hEE;
      drop_done++;
    end else if (keep_req != keep_done) begin
      m_pushout  = 1'b1;
      m_data_out = 8'h5C;
      exp_rd.push_back(8'h5C);
      keep_done++;
    end else if (pend.size() > 0 && (!slave_rand || $urandom_range(0, 2) == 0)) begin
      m_pushout  = 1'b1;
      m_data_out = pend.pop_front();
      exp_rd.push_back(m_data_out);
    end
  end

  // Monitor: burst beats toward the master and bytes popped by the host.
  always @(negedge CLK) begin
    if (RST) begin
      mon_rem = 0;
      mon_low = 0;
    end else begin
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) checkOutput("rd_unexpected", {24'h0, rd_data}, 32'hFFFF_FFFF);
        else checkOutput("rd_data", {24'h0, rd_data}, {24'h0, exp_rd.pop_front()});
      end
      if (mon_rem > 0) begin
        checkOutput("burst_pushin", {31'h0, m_pushin}, 1);
        if (mon_write) mon_exp = (exp_wr.size() > 0) ? exp_wr.pop_front() : 8'hxx;
        else           mon_exp = 8'h00;
        checkOutput("burst_data", {24'h0, m_data_in}, {24'h0, mon_exp});
        mon_rem--;
        if (mon_rem == 0) mon_low = 1;
      end else if (mon_low) begin
        checkOutput("burst_end", {31'h0, m_pushin}, 0);
        mon_low = 0;
      end else if (m_pushin) begin
        if (exp_cmd.size() == 0) checkOutput("burst_unexpected", {24'h0, m_data_in}, 32'hFFFF_FFFF);
        else begin
          mon_c = exp_cmd[0];
          if (m_canin) begin
            checkOutput("addr_byte", {24'h0, m_data_in}, {24'h0, mon_c.addr, mon_c.write});
            exp_cmd.delete(0);
            mon_rem   = mon_c.len;
            mon_write = mon_c.write;
            if (!mon_c.write)
              for (int i = 0; i < mon_c.len; i++)
                pend.push_back(ret_seq ? (ret_base + 8'(i)) : 8'($urandom));
            if (mon_c.len == 0) mon_low = 1;
          end else begin
            checkOutput("addr_hold", {24'h0, m_data_in}, {24'h0, mon_c.addr, mon_c.write});
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [6:0] a, input bit w, input int len);
    int   waited = 0;
    cmd_t c;
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_len = 4'(len);
    @(negedge CLK);
    while (!cmd_ready && waited < 500) begin waited++; @(negedge CLK); end
    if (!cmd_ready) checkOutput("cmd_accept_timeout", 0, 1);
    else begin
      @(posedge CLK);
      c.addr = a; c.write = w; c.len = len;
      exp_cmd.push_back(c);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic pushWriteByte(input logic [7:0] b);
    int waited = 0;
    @(posedge CLK); #1;
    wr_valid = 1'b1; wr_data = b;
    @(negedge CLK);
    while (!wr_ready && waited < 500) begin waited++; @(negedge CLK); end
    if (!wr_ready) checkOutput("wr_accept_timeout", 0, 1);
    else begin
      @(posedge CLK);
      exp_wr.push_back(b);
    end
    #1 wr_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget, input bit need_rd);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (exp_cmd.size() == 0 && pend.size() == 0 && !busy && !m_pushin &&
          (!need_rd || (exp_rd.size() == 0 && !rd_valid))) begin
        ok = 1;
        break;
      end
    end
    checkOutput(name, {31'h0, ok}, 1);
  endtask

  task automatic waitNoPushin(input string name, input int cycles);
    bit seen = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (m_pushin) seen = 1;
    end
    checkOutput(name, {31'h0, seen}, 0);
  endtask

  task automatic popBytes(input int n);
    int waited = 0;
    pop_req += n;
    while (pop_done != pop_req && waited < 100) begin waited++; @(negedge CLK); end
    checkOutput("pop_timeout", {31'h0, (pop_done == pop_req)}, 1);
    @(negedge CLK);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] held;
    bit         stable;
    bit         found;
    int         len;
    bit         w;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset_pushin",   {31'h0, m_pushin}, 0);
    checkOutput("reset_data_in",  {24'h0, m_data_in}, 0);
    checkOutput("reset_rd_valid", {31'h0, rd_valid}, 0);
    checkOutput("reset_busy",     {31'h0, busy}, 0);
    checkOutput("reset_overflow", {31'h0, rd_overflow}, 0);
    checkOutput("reset_cmd_ready",{31'h0, cmd_ready}, 1);
    checkOutput("reset_wr_ready", {31'h0, wr_ready}, 1);

    $display("[TB] write 0x25 len 5");
    canin_dir = 1;
    applyStimulus(7'h25, 1, 5);
    pushWriteByte(8'h11); pushWriteByte(8'h22); pushWriteByte(8'h33);
    pushWriteByte(8'h44); pushWriteByte(8'h55);
    waitIdle("write5_done", 200, 1);

    $display("[TB] write len 3 with a late third byte");
    applyStimulus(7'h3A, 1, 3);
    pushWriteByte(8'hA1); pushWriteByte(8'hA2);
    waitNoPushin("no_partial_burst", 10);
    pushWriteByte(8'hA3);
    waitIdle("write3_done", 200, 1);

    $display("[TB] read 0x25 len 3 with m_canin held low");
    canin_dir = 0;
    host_dir  = 1;
    applyStimulus(7'h25, 0, 3);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLK);
      if (m_pushin) found = 1;
    end
    checkOutput("hold_start", {31'h0, found}, 1);
    held   = m_data_in;
    stable = 1;
    repeat (8) begin
      @(negedge CLK);
      if (!m_pushin || m_data_in !== held) stable = 0;
    end
    checkOutput("hold_stable", {31'h0, stable}, 1);
    checkOutput("hold_addr", {24'h0, held}, {24'h0, 7'h25, 1'b0});
    canin_dir = 1;
    waitIdle("read3_done", 200, 1);

    $display("[TB] read space reservation");
    host_dir = 0;
    applyStimulus(7'h11, 0, 8);
    waitIdle("fill8_done", 200, 0);
    checkOutput("fill8_rd_valid", {31'h0, rd_valid}, 1);
    ret_seq  = 1;
    ret_base = 8'hAA;
    applyStimulus(7'h12, 0, 15);
    waitNoPushin("rd_space_block_8", 20);
    popBytes(6);
    waitNoPushin("rd_space_block_2", 10);
    popBytes(1);
    waitIdle("read15_done", 300, 0);
    ret_seq  = 0;
    host_dir = 1;
    waitIdle("read15_drain", 300, 1);
    checkOutput("no_overflow_reserved", {31'h0, rd_overflow}, 0);

    $display("[TB] randomized traffic");
    canin_rand = 1;
    host_rand  = 1;
    slave_rand = 1;
    for (int n = 0; n < 40; n++) begin
      w   = ($urandom_range(0, 1) == 1);
      len = $urandom_range(0, 15);
      applyStimulus(7'($urandom), w, len);
      if (w) for (int k = 0; k < len; k++) pushWriteByte(8'($urandom));
    end
    waitIdle("random_done", 20000, 1);
    canin_rand = 0;
    host_rand  = 0;
    slave_rand = 0;
    host_dir   = 0;
    checkOutput("random_no_overflow", {31'h0, rd_overflow}, 0);

    $display("[TB] read FIFO overflow");
    applyStimulus(7'h20, 0, 15);
    applyStimulus(7'h21, 0, 1);
    waitIdle("fill16_done", 300, 0);
    @(negedge CLK);
    drop_req++;
    repeat (3) @(negedge CLK);
    checkOutput("overflow_set", {31'h0, rd_overflow}, 1);
    checkOutput("overflow_busy", {31'h0, busy}, 0);
    host_dir = 1;
    waitIdle("overflow_drain", 300, 1);
    checkOutput("overflow_sticky", {31'h0, rd_overflow}, 1);
    keep_req++;
    waitIdle("unsolicited_kept", 100, 1);
    checkOutput("unsolicited_busy", {31'h0, busy}, 0);

    $display("[TB] reset during a write burst");
    applyStimulus(7'h25, 1, 5);
    for (int k = 0; k < 5; k++) pushWriteByte(8'h60 + 8'(k));
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK);
      if (mon_rem >= 2 && mon_rem <= 4) found = 1;
    end
    checkOutput("midburst_reached", {31'h0, found}, 1);
    #1 RST = 1'b1;
    @(negedge CLK);
    checkOutput("rst_pushin",    {31'h0, m_pushin}, 0);
    checkOutput("rst_busy",      {31'h0, busy}, 0);
    checkOutput("rst_wr_ready",  {31'h0, wr_ready}, 1);
    checkOutput("rst_cmd_ready", {31'h0, cmd_ready}, 1);
    checkOutput("rst_rd_valid",  {31'h0, rd_valid}, 0);
    checkOutput("rst_overflow",  {31'h0, rd_overflow}, 0);
    exp_cmd.delete();
    exp_wr.delete();
    #1 RST = 1'b0;
    applyStimulus(7'h5A, 1, 2);
    pushWriteByte(8'hC3);
    pushWriteByte(8'h3C);
    waitIdle("post_reset_write", 200, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
